// File: rtl/slider_arb_pkg.sv
// Shared types and constants for the slider step arbiter: FSM states, step weights
// and the default saturation ceiling.
package slider_arb_pkg;

    localparam int unsigned NumSliders      = 4;
    localparam int unsigned NumberW         = 14;
    localparam int unsigned DefaultMaxValue = 9999;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StCooldown
    } arb_state_e;

    // Decimal weight of each slider position: 1, 10, 100, 1000.
    function automatic logic [NumberW-1:0] step_weight(input logic [1:0] idx);
        logic [NumberW-1:0] w;
        case (idx)
            2'd0:    w = 14'd1;
            2'd1:    w = 14'd10;
            2'd2:    w = 14'd100;
            default: w = 14'd1000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/slider_hold_timer.sv
// Per-slider hold timer: counts consecutive high cycles and emits a one-cycle expiry
// pulse every HOLD_CYCLES cycles while the slider stays high.
module slider_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic level,
    output logic expire
);

    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            hit;

    assign hit    = level && (cnt_q == CntW'(HOLD_CYCLES - 1));
    assign expire = hit;

    // Restart from zero on expiry so a held slider auto-repeats.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !level || hit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/slider_step_arbiter.sv
// Turns held sliders into decimal step requests, serves them round-robin one at a time
// with a cooldown, and accumulates a saturating number.
module slider_step_arbiter
    import slider_arb_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned COOL_CYCLES = 2,
    parameter int unsigned MAX_VALUE   = DefaultMaxValue
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NumSliders-1:0] slider,
    input  logic                  clear,
    input  logic                  enable,
    output logic [NumberW-1:0]    number,
    output logic [NumSliders-1:0] grant,
    output logic                  step_valid,
    output logic                  busy,
    output logic                  sat
);

    localparam int unsigned CoolW = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

    arb_state_e            state_q, state_d;
    logic [NumSliders-1:0] pending_q, pending_d;
    logic [NumSliders-1:0] pending_clr;
    logic [NumSliders-1:0] expire;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [1:0]            winner_q, winner_d;
    logic [CoolW-1:0]      cool_q, cool_d;
    logic [NumberW-1:0]    number_q, number_d;
    logic                  sat_q, sat_d;
    logic [NumberW:0]      sum;
    logic [1:0]            pick;
    logic [1:0]            rr_idx;
    logic                  found;

    for (genvar k = 0; k < NumSliders; k++) begin : g_hold
        slider_hold_timer #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_hold (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .level (slider[k]),
            .expire(expire[k])
        );
    end

    // Round-robin search starting at rr_ptr.
    always_comb begin
        pick   = '0;
        found  = 1'b0;
        rr_idx = '0;
        for (int i = 0; i < NumSliders; i++) begin
            rr_idx = rr_ptr_q + 2'(i);
            if (!found && pending_q[rr_idx]) begin
                found = 1'b1;
                pick  = rr_idx;
            end
        end
    end

    assign sum = {1'b0, number_q} + {1'b0, step_weight(winner_q)};

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        cool_d      = cool_q;
        number_d    = number_q;
        sat_d       = sat_q;
        rr_ptr_d    = rr_ptr_q;
        pending_clr = '0;

        unique case (state_q)
            StIdle: begin
                if (enable && found) begin
                    state_d  = StApply;
                    winner_d = pick;
                end
            end
            StApply: begin
                if (sum > (NumberW + 1)'(MAX_VALUE)) begin
                    number_d = NumberW'(MAX_VALUE);
                    sat_d    = 1'b1;
                end else begin
                    number_d = sum[NumberW-1:0];
                end
                pending_clr[winner_q] = 1'b1;
                rr_ptr_d              = winner_q + 2'd1;
                cool_d                = '0;
                state_d               = (COOL_CYCLES == 0) ? StIdle : StCooldown;
            end
            StCooldown: begin
                if (cool_q == CoolW'(COOL_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    cool_d = cool_q + CoolW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh expiry in the grant cycle keeps the bit set.
        pending_d = (pending_q & ~pending_clr) | expire;

        if (clear) begin
            state_d   = StIdle;
            winner_d  = '0;
            cool_d    = '0;
            number_d  = '0;
            sat_d     = 1'b0;
            rr_ptr_d  = '0;
            pending_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            winner_q  <= '0;
            cool_q    <= '0;
            number_q  <= '0;
            sat_q     <= 1'b0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            cool_q    <= cool_d;
            number_q  <= number_d;
            sat_q     <= sat_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
        end
    end

    assign step_valid = (state_q == StApply);
    assign busy       = (state_q != StIdle);
    assign grant      = step_valid ? (NumSliders'(1) << winner_q) : '0;
    assign number     = number_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_slider_step_arbiter.sv
// Directed self-checking bench for slider_step_arbiter with default parameters.
module tb_slider_step_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  slider = '0;
    logic        clear = 1'b0;
    logic        enable = 1'b1;
    logic [13:0] number;
    logic [3:0]  grant;
    logic        step_valid;
    logic        busy;
    logic        sat;

    int total = 0;
    int bad = 0;

    slider_step_arbiter #(
        .HOLD_CYCLES(4),
        .COOL_CYCLES(2),
        .MAX_VALUE  (9999)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .slider    (slider),
        .clear     (clear),
        .enable    (enable),
        .number    (number),
        .grant     (grant),
        .step_valid(step_valid),
        .busy      (busy),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Hold one slider for exactly one hold period, then let the step drain.
    task automatic step_once(input int k);
        slider = 4'(1 << k);
        repeat (4) tick();
        slider = '0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({number, grant, step_valid, busy, sat} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {number, grant, step_valid, busy, sat});
        end
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || number !== 14'd0) begin
            bad++;
            $display("FAIL reset_release got busy=%0b number=%0d exp 0 0", busy, number);
        end
    endtask

    task automatic test_single_hold();
        int g_cnt = 0;
        int first_g = -1;
        do_clear();
        slider = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) slider = '0;
            if (grant == 4'b0001) begin
                g_cnt++;
                if (first_g < 0) first_g = c;
            end else if (grant !== 4'b0000) begin
                total++;
                bad++;
                $display("FAIL single_grant_value cycle=%0d got=%b exp=0001/0000", c, grant);
            end
            tick();
        end
        total++;
        if (g_cnt != 2) begin
            bad++;
            $display("FAIL single_grant_count got=%0d exp=2", g_cnt);
        end
        total++;
        if (first_g != 5) begin
            bad++;
            $display("FAIL single_first_grant_cycle got=%0d exp=5", first_g);
        end
        total++;
        if (number !== 14'd2) begin
            bad++;
            $display("FAIL single_number got=%0d exp=2", number);
        end
    endtask

    task automatic test_all_sliders();
        logic [3:0] exp_g [4];
        int exp_c [4];
        int n = 0;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
        exp_c[0] = 5; exp_c[1] = 9; exp_c[2] = 13; exp_c[3] = 17;
        do_clear();
        slider = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            if (c == 4) slider = '0;
            total++;
            if (step_valid !== (grant != 4'b0000)) begin
                bad++;
                $display("FAIL all_step_valid cycle=%0d got=%b grant=%b", c, step_valid, grant);
            end
            if (c == 6 || c == 7) begin
                total++;
                if (busy !== 1'b1 || step_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL all_cooldown cycle=%0d got busy=%b sv=%b exp 1 0", c, busy,
                             step_valid);
                end
            end
            if (grant != 4'b0000) begin
                total++;
                if (n > 3 || grant !== exp_g[n] || c != exp_c[n]) begin
                    bad++;
                    $display("FAIL all_grant_order idx=%0d cycle=%0d got=%b exp=%b@%0d", n, c,
                             grant, exp_g[n & 3], exp_c[n & 3]);
                end
                n++;
            end
            tick();
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL all_grant_count got=%0d exp=4", n);
        end
        total++;
        if (number !== 14'd1111) begin
            bad++;
            $display("FAIL all_number got=%0d exp=1111", number);
        end
    endtask

    task automatic test_enable_gate();
        int stray = 0;
        do_clear();
        enable = 1'b0;
        slider = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) slider = '0;
            if (grant !== 4'b0000 || busy !== 1'b0) stray++;
            tick();
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL enable_low_grant got=%0d cycles exp=0", stray);
        end
        enable = 1'b1;
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL enable_same_cycle got=%b exp=0000", grant);
        end
        tick();
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL enable_grant got=%b exp=0100", grant);
        end
        repeat (4) tick();
        total++;
        if (number !== 14'd100) begin
            bad++;
            $display("FAIL enable_number got=%0d exp=100", number);
        end
    endtask

    task automatic test_short_holds();
        int stray = 0;
        do_clear();
        for (int c = 0; c < 14; c++) begin
            slider = (c < 3 || (c >= 4 && c < 7)) ? 4'b0001 : 4'b0000;
            if (grant !== 4'b0000) stray++;
            tick();
        end
        total++;
        if (stray != 0 || number !== 14'd0) begin
            bad++;
            $display("FAIL short_holds got grants=%0d number=%0d exp 0 0", stray, number);
        end
    endtask

    task automatic test_saturate();
        do_clear();
        for (int k = 3; k >= 0; k--) begin
            for (int i = 0; i < ((k == 0) ? 5 : 9); i++) step_once(k);
        end
        total++;
        if (number !== 14'd9995 || sat !== 1'b0) begin
            bad++;
            $display("FAIL sat_preload got number=%0d sat=%b exp 9995 0", number, sat);
        end
        step_once(1);
        total++;
        if (number !== 14'd9999 || sat !== 1'b1) begin
            bad++;
            $display("FAIL sat_clamp got number=%0d sat=%b exp 9999 1", number, sat);
        end
        do_clear();
        total++;
        if (number !== 14'd0 || sat !== 1'b0) begin
            bad++;
            $display("FAIL sat_clear got number=%0d sat=%b exp 0 0", number, sat);
        end
    endtask

    task automatic test_reset_cooldown();
        int stray = 0;
        do_clear();
        slider = 4'b1001;
        repeat (4) tick();
        slider = '0;
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL rst_cd_first_grant got=%b exp=0001", grant);
        end
        tick();
        total++;
        if (busy !== 1'b1 || number !== 14'd1) begin
            bad++;
            $display("FAIL rst_cd_in_cooldown got busy=%b number=%0d exp 1 1", busy, number);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({number, grant, step_valid, busy, sat} !== 21'd0) begin
            bad++;
            $display("FAIL rst_cd_async got=%h exp=0", {number, grant, step_valid, busy, sat});
        end
        tick();
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (grant !== 4'b0000 || busy !== 1'b0) stray++;
        end
        total++;
        if (stray != 0 || number !== 14'd0) begin
            bad++;
            $display("FAIL rst_cd_after got active=%0d number=%0d exp 0 0", stray, number);
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_all_sliders();
        test_enable_gate();
        test_short_holds();
        test_saturate();
        test_reset_cooldown();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
